compare_event_monitor: RTL and testbench
========================================

COMPARE_EVENT_MONITOR -- requirements
Module: compare_event_monitor

Interface
REQ-001 SHALL have parameter PERSIST, default 3: consecutive identical valid samples needed to change state (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of each entry counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: comparator flags valid this cycle.
REQ-006 SHALL have port a_gt_b, input, 1 bit: comparator flag a>b.
REQ-007 SHALL have port a_eq_b, input, 1 bit: comparator flag a==b.
REQ-008 SHALL have port a_lt_b, input, 1 bit: comparator flag a<b.
REQ-009 SHALL have port clr, input, 1 bit: synchronous clear of the counters and flag_err.
REQ-010 SHALL have port state, output, 2 bits: 00 UNKNOWN, 01 LOW, 10 MATCH, 11 HIGH.
REQ-011 SHALL have port chg, output, 1 bit: one-cycle pulse on a state change.
REQ-012 SHALL have ports hi_cnt, eq_cnt and lo_cnt, output, CNT_W bits each: entries into HIGH, MATCH and LOW.
REQ-013 SHALL have port flag_err, output, 1 bit: sticky flag for an illegal flag combination.

Function
REQ-014 SHALL sample the flags only on cycles with in_valid=1; cycles with in_valid=0 change nothing and do not break a run.
REQ-015 SHALL treat a valid sample as legal only if exactly one of a_gt_b, a_eq_b, a_lt_b is 1.
REQ-016 SHALL respond to a valid illegal sample by setting flag_err on that edge and leaving the run tracker, state and counters untouched.
REQ-017 SHALL keep internal registers last_rel (GT/EQ/LT) and run_len (4 bits).
REQ-018 SHALL, on a legal sample whose relation equals last_rel, increment run_len, saturating at PERSIST.
REQ-019 SHALL, on any other legal sample, load run_len=1 and set last_rel to the new relation.
REQ-020 SHALL, when the updated run_len equals PERSIST, set state to the matching state (GT->HIGH, EQ->MATCH, LT->LOW) on the same edge that registers the sample.
REQ-021 SHALL therefore show the new state one clock after the qualifying sample.
REQ-022 SHALL make no transition and no chg when the target state equals the current state.
REQ-023 SHALL never return to UNKNOWN except through rst.
REQ-024 SHALL, with PERSIST=1, change state on every legal valid sample whose relation differs from the current state.
REQ-025 SHALL assert chg for exactly one cycle, registered with the state update, on every state change.
REQ-026 SHALL increment the counter matching the entered state by 1 on each state change, saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL, on clr=1, zero all three counters and flag_err on that edge.
REQ-028 SHALL let clr override a same-cycle counter increment or error set, so the counters read 0 and flag_err reads 0.
REQ-029 SHALL leave state, run_len, last_rel and chg unaffected by clr, so the state update and chg still occur in that cycle.

Reset
REQ-030 SHALL, with rst=1 at an edge, set state=00, chg=0, all counters=0, flag_err=0, run_len=0 and last_rel=EQ.
REQ-031 SHALL give rst priority over in_valid and clr.
REQ-032 SHALL discard a partial run when rst is asserted mid-run, so the next legal sample starts a run at run_len=1.

Verification (PERSIST=3, CNT_W=8)
REQ-033 SHALL verify: after reset, 3 consecutive valid GT samples -> state=11 and chg=1 in the cycle after the 3rd sample; hi_cnt=1.
REQ-034 SHALL verify: pattern GT,GT,LT,GT,GT with valid=0 gaps between samples -> state stays 00, no chg, all counters 0.
REQ-035 SHALL verify: valid sample with a_gt_b=1 and a_eq_b=1 in the middle of a GT run -> flag_err=1 and the run still completes on the next GT sample; then clr -> flag_err=0.
REQ-036 SHALL verify: state HIGH, then 3 EQ samples, then 5 more EQ samples -> exactly one chg pulse, state=10, eq_cnt=1.
REQ-037 SHALL verify: alternate 3xGT and 3xLT 300 times -> hi_cnt=255 and lo_cnt=255 (saturated).
REQ-038 SHALL verify: 2 LT samples, rst for one cycle, then 2 LT samples -> state=00; a 3rd LT sample -> state=01.

Source files
------------

// File: rtl/compare_event_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare_event_monitor : debounced comparator-relation tracker with entry counters
// Revision 1.0
// ---------------------------------------------------------------------------
module compare_event_monitor #(
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  input  logic             a_lt_b,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             chg,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lo_cnt,
  output logic             flag_err
);

  localparam logic [3:0] PERSIST_L = 4'(PERSIST);

  // Relations share the state encoding so the target state is the relation itself.
  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_LOW     = 2'b01,
    ST_MATCH   = 2'b10,
    ST_HIGH    = 2'b11
  } state_t;

  state_t     last_rel;
  logic [3:0] run_len;

  logic       legal;
  logic       illegal;
  state_t     new_rel;
  logic [3:0] next_run;
  logic       enter;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    legal    = in_valid && $onehot({a_gt_b, a_eq_b, a_lt_b});
    illegal  = in_valid && !$onehot({a_gt_b, a_eq_b, a_lt_b});
    new_rel  = a_gt_b ? ST_HIGH : (a_eq_b ? ST_MATCH : ST_LOW);
    next_run = 4'd1;
    if (new_rel == last_rel)
      next_run = (run_len >= PERSIST_L) ? PERSIST_L : run_len + 4'd1;
    enter    = legal && (next_run == PERSIST_L) && (new_rel != state_t'(state));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNKNOWN;
      chg      <= 1'b0;
      hi_cnt   <= '0;
      eq_cnt   <= '0;
      lo_cnt   <= '0;
      flag_err <= 1'b0;
      run_len  <= 4'd0;
      last_rel <= ST_MATCH;
    end else begin
      chg <= enter;
      if (legal) begin
        last_rel <= new_rel;
        run_len  <= next_run;
      end
      if (enter)
        state <= new_rel;
      // clr wins over a same-edge increment or error, but not over the state update.
      if (clr) begin
        hi_cnt   <= '0;
        eq_cnt   <= '0;
        lo_cnt   <= '0;
        flag_err <= 1'b0;
      end else begin
        if (illegal)
          flag_err <= 1'b1;
        if (enter) begin
          case (new_rel)
            ST_HIGH:  hi_cnt <= sat_inc(hi_cnt);
            ST_MATCH: eq_cnt <= sat_inc(eq_cnt);
            ST_LOW:   lo_cnt <= sat_inc(lo_cnt);
            default:  ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compare_event_monitor.sv
`default_nettype none
// Bench for compare_event_monitor: directed scenarios plus random traffic against a
// history-based reference model.
module tb_compare_event_monitor;

  localparam int PERSIST = 3;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             a_gt_b = 1'b0;
  logic             a_eq_b = 1'b0;
  logic             a_lt_b = 1'b0;
  logic             clr = 1'b0;
  logic [1:0]       state;
  logic             chg;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic             flag_err;

  compare_event_monitor #(.PERSIST(PERSIST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .clr(clr),
    .state(state), .chg(chg), .hi_cnt(hi_cnt), .eq_cnt(eq_cnt),
    .lo_cnt(lo_cnt), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the state changes when the last PERSIST legal samples agree.
  int m_state = 0, m_chg = 0, m_hi = 0, m_eq = 0, m_lo = 0, m_err = 0;
  int m_ok = 0;
  int hist[$];

  always @(posedge clk) begin
    int n, rel, same;
    if (rst) begin
      m_state = 0; m_chg = 0; m_hi = 0; m_eq = 0; m_lo = 0; m_err = 0;
      hist.delete();
      m_ok = 1;
    end else begin
      m_chg = 0;
      if (in_valid) begin
        n = int'(a_gt_b) + int'(a_eq_b) + int'(a_lt_b);
        if (n != 1) begin
          m_err = 1;
        end else begin
          rel = a_gt_b ? 3 : (a_eq_b ? 2 : 1);
          hist.push_back(rel);
          if (hist.size() > PERSIST) void'(hist.pop_front());
          if (hist.size() == PERSIST) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != rel) same = 0;
            if (same != 0 && rel != m_state) begin
              m_state = rel;
              m_chg = 1;
              if (rel == 3) m_hi = (m_hi < CMAX) ? m_hi + 1 : CMAX;
              if (rel == 2) m_eq = (m_eq < CMAX) ? m_eq + 1 : CMAX;
              if (rel == 1) m_lo = (m_lo < CMAX) ? m_lo + 1 : CMAX;
            end
          end
        end
      end
      if (clr) begin
        m_hi = 0; m_eq = 0; m_lo = 0; m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok != 0) begin
      tests++;
      if (int'(state) != m_state || int'(chg) != m_chg || int'(hi_cnt) != m_hi ||
          int'(eq_cnt) != m_eq || int'(lo_cnt) != m_lo || int'(flag_err) != m_err) begin
        fails++;
        $display("FAIL model t=%0t: got st=%0d chg=%0d hi=%0d eq=%0d lo=%0d err=%0d, want st=%0d chg=%0d hi=%0d eq=%0d lo=%0d err=%0d",
                 $time, state, chg, hi_cnt, eq_cnt, lo_cnt, flag_err,
                 m_state, m_chg, m_hi, m_eq, m_lo, m_err);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge register them, then return to idle.
  task automatic drive(input logic v, input logic g, input logic e, input logic l,
                       input logic c, input logic r);
    in_valid = v; a_gt_b = g; a_eq_b = e; a_lt_b = l; clr = c; rst = r;
    @(posedge clk);
    #3;
    in_valid = 1'b0; a_gt_b = 1'b0; a_eq_b = 1'b0; a_lt_b = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic gt();  drive(1, 1, 0, 0, 0, 0); endtask
  task automatic eq();  drive(1, 0, 1, 0, 0, 0); endtask
  task automatic lt();  drive(1, 0, 0, 1, 0, 0); endtask
  task automatic idle(); drive(0, 0, 0, 0, 0, 0); endtask

  initial begin
    int pulses;
    @(negedge clk);
    #2;

    do_reset();
    check("reset_state", int'(state), 0);
    check("reset_chg", int'(chg), 0);
    check("reset_cnts", int'(hi_cnt) + int'(eq_cnt) + int'(lo_cnt), 0);
    check("reset_err", int'(flag_err), 0);

    gt(); gt();
    check("gt2_state", int'(state), 0);
    gt();
    check("gt3_state", int'(state), 3);
    check("gt3_chg", int'(chg), 1);
    check("gt3_hi_cnt", int'(hi_cnt), 1);
    idle();
    check("gt3_chg_drop", int'(chg), 0);

    do_reset();
    gt(); idle(); gt(); idle(); lt(); idle(); gt(); idle(); gt(); idle();
    check("broken_state", int'(state), 0);
    check("broken_cnts", int'(hi_cnt) + int'(eq_cnt) + int'(lo_cnt), 0);

    do_reset();
    gt(); gt();
    drive(1, 1, 1, 0, 0, 0);
    check("illegal_err", int'(flag_err), 1);
    check("illegal_state", int'(state), 0);
    gt();
    check("illegal_run_state", int'(state), 3);
    check("illegal_run_hi", int'(hi_cnt), 1);
    drive(0, 0, 0, 0, 1, 0);
    check("clr_err", int'(flag_err), 0);
    check("clr_hi", int'(hi_cnt), 0);

    do_reset();
    gt(); gt(); gt();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      eq();
      if (chg) pulses++;
    end
    check("eq_pulses", pulses, 1);
    check("eq_state", int'(state), 2);
    check("eq_cnt", int'(eq_cnt), 1);

    // clr on the same edge as a state entry: state moves, counter stays 0.
    lt(); lt();
    drive(1, 0, 0, 1, 1, 0);
    check("clr_entry_state", int'(state), 1);
    check("clr_entry_chg", int'(chg), 1);
    check("clr_entry_lo", int'(lo_cnt), 0);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      gt(); gt(); gt();
      lt(); lt(); lt();
    end
    check("sat_hi", int'(hi_cnt), 255);
    check("sat_lo", int'(lo_cnt), 255);

    do_reset();
    lt(); lt();
    do_reset();
    lt(); lt();
    check("rst_mid_state", int'(state), 0);
    lt();
    check("rst_mid_after", int'(state), 1);

    // Random traffic, checked every cycle by the model compare.
    for (int i = 0; i < 4000; i++) begin
      logic v, g, e, l, c, r;
      int k;
      v = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, 19);
      if (k < 17) begin
        // bias toward runs of the same relation
        k = (i / 4 + $urandom_range(0, 1)) % 3;
        g = (k == 0); e = (k == 1); l = (k == 2);
      end else begin
        {g, e, l} = 3'($urandom_range(0, 7));
      end
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 199) == 0);
      drive(v, g, e, l, c, r);
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
